imem_block_responder: RTL and testbench

- Instruction-memory responder on the cache-to-memory refill interface; serves 128-bit (16-byte) block reads requested by the instruction cache.
- Stores 64 blocks (1 KiB) and answers each request after a fixed, parameterised latency using an imem_read / imem_busywait handshake.
- Has a byte-wide load port so the bench or boot logic can place program images.
- Sits between the instruction cache and the top-level program image.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_block_ram.sv | 51 +++++
 rtl/imem_block_responder.sv | 104 ++++++++++
 tb/tb_imem_block_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory refill interface.
// Latency: n/a (types, constants and address helpers only).
// Backpressure: n/a.
package imem_pkg;

  localparam int BLOCK_BITS   = 128;
  localparam int BLOCK_ADDR_W = 6;
  localparam int BYTE_ADDR_W  = 10;
  localparam int LANE_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } imem_state_e;

  // Block index of a byte address.
  function automatic logic [BLOCK_ADDR_W-1:0] block_of(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return byte_addr[BYTE_ADDR_W-1:LANE_W];
  endfunction

  // Byte lane of a byte address within its block.
  function automatic logic [LANE_W-1:0] lane_of(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return byte_addr[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/imem_block_ram.sv
// Block storage: byte-lane write port, full-block synchronous read into an output register.
// Latency: read data appears in the register one edge after rd_en; writes land on the same edge.
// Backpressure: none; a write and a read on the same edge returns the pre-write block.
module imem_block_ram
  import imem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [BYTE_ADDR_W-1:0]  wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    rd_en,
  input  logic [BLOCK_ADDR_W-1:0] rd_addr,
  output logic [BLOCK_BITS-1:0]   rd_data
);

  // Storage is deliberately not reset so a loaded program image survives reset.
  logic [BLOCK_BITS-1:0] mem_q [DEPTH];

  logic [BLOCK_BITS-1:0] rd_data_q;
  logic [BLOCK_BITS-1:0] rd_data_d;

  // Byte-lane write; non-blocking update gives read-before-write against the capture below.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[block_of(wr_addr)][{lane_of(wr_addr), 3'b000} +: 8] <= wr_data;
    end
  end

  // Output register loads a whole block on rd_en and otherwise holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Output register; cleared by reset, memory contents untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_block_responder.sv
// Instruction-memory responder: serves 128-bit block reads to the I-cache via imem_read/imem_busywait.
// Latency: busywait high for LATENCY cycles from the request cycle; block valid in the first low cycle.
// Backpressure: busywait stalls the cache; one forced busywait-low cycle between back-to-back requests.
module imem_block_responder
  import imem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int NUM_BLOCKS = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    imem_read,
  input  logic [BLOCK_ADDR_W-1:0] imem_pc,
  output logic [BLOCK_BITS-1:0]   imem_readdata,
  output logic                    imem_busywait,
  input  logic                    load_en,
  input  logic [BYTE_ADDR_W-1:0]  load_addr,
  input  logic [7:0]              load_data
);

  // The request cycle and the capture cycle each consume one busywait cycle;
  // the counter covers the READ cycles between them.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  imem_state_e              state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [BLOCK_ADDR_W-1:0]  addr_q, addr_d;
  logic                     rd_en;
  logic [BLOCK_ADDR_W-1:0]  rd_addr;

  // Next-state, counter, capture strobe and the combinational busywait.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    rd_en         = 1'b0;
    rd_addr       = addr_q;
    imem_busywait = !reset && ((state_q == IDLE && imem_read) || state_q == READ);

    case (state_q)
      IDLE: begin
        if (imem_read) begin
          addr_d = imem_pc;
          if (LATENCY == 1) begin
            rd_en   = 1'b1;
            rd_addr = imem_pc;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = READ;
          end
        end
      end
      READ: begin
        // imem_pc and imem_read are ignored here: an accepted transfer always completes.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rd_en   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A still-high imem_read is only accepted from IDLE on the next edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A request seen under reset is never accepted and no capture happens.
    if (reset) begin
      rd_en = 1'b0;
    end
  end

  // FSM, counter and latched address with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  imem_block_ram #(
    .DEPTH (NUM_BLOCKS)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (imem_readdata)
  );

endmodule

// File: tb/tb_imem_block_responder.sv
// Bench for imem_block_responder: LATENCY=4 and LATENCY=1 builds sharing clock, reset and load port.
module tb_imem_block_responder;

  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         imem_read, imem_read1;
  logic [5:0]   imem_pc, imem_pc1;
  logic [127:0] rdata, rdata1;
  logic         bw, bw1;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [7:0]   load_data;

  localparam logic [127:0] B5   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] B5AA = 128'h0F0E0D0C_0B0A0908_07060504_030201AA;
  localparam logic [127:0] B9   = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

  int pass_cnt = 0;
  int total    = 0;

  // Reference memory: one 128-bit word per block, byte n at [8n+7:8n].
  bit [127:0] model [64];

  typedef struct {
    logic [5:0]   pc;
    logic [5:0]   pc_mid;
    bit           drop;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [4];

  always #5 clock = ~clock;

  imem_block_responder #(.LATENCY(LAT), .NUM_BLOCKS(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_read     (imem_read),
    .imem_pc       (imem_pc),
    .imem_readdata (rdata),
    .imem_busywait (bw),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data)
  );

  imem_block_responder #(.LATENCY(1), .NUM_BLOCKS(64)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .imem_read     (imem_read1),
    .imem_pc       (imem_pc1),
    .imem_readdata (rdata1),
    .imem_busywait (bw1),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // One clock: the model takes the load seen at the edge, then return at the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (load_en) model[load_addr[9:4]][8*load_addr[3:0] +: 8] = load_data;
    @(negedge clock);
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    cycle();
    load_en = 1'b0;
  endtask

  // One request on the LATENCY=4 build: busywait must be high for exactly LAT cycles,
  // then low with the block as it stood just before the capturing edge.
  task automatic req(input logic [5:0] pc, input logic [5:0] pc_mid, input bit drop,
                     input bit rnd, input bit cap_ld, input logic [9:0] cap_addr,
                     input logic [7:0] cap_dat, input bit use_const, input logic [127:0] exp_c);
    logic [127:0] snap;
    snap = '0;
    imem_read = 1'b1;
    imem_pc   = pc;
    for (int i = 0; i < LAT; i++) begin
      #1;
      chk($sformatf("busy cyc%0d blk%0d", i, pc), {127'b0, bw}, 128'd1);
      if (i == 2) imem_pc = pc_mid;
      if (i == 1 && drop) imem_read = 1'b0;
      load_en = 1'b0;
      if (rnd) begin
        load_en   = 1'($urandom_range(0, 1));
        load_addr = 10'($urandom);
        load_data = 8'($urandom);
      end
      if (i == LAT - 1) begin
        snap = model[pc];
        if (cap_ld) begin
          load_en = 1'b1; load_addr = cap_addr; load_data = cap_dat;
        end
      end
      cycle();
    end
    load_en = 1'b0;
    #1;
    chk($sformatf("done busy low blk%0d", pc), {127'b0, bw}, 128'd0);
    chk($sformatf("data blk%0d", pc), rdata, use_const ? exp_c : snap);
  endtask

  initial begin
    logic [127:0] snap;
    vecs[0] = '{pc: 6'd5, pc_mid: 6'd9, drop: 1'b0, exp: B5};
    vecs[1] = '{pc: 6'd9, pc_mid: 6'd5, drop: 1'b1, exp: B9};
    vecs[2] = '{pc: 6'd5, pc_mid: 6'd5, drop: 1'b1, exp: B5};
    vecs[3] = '{pc: 6'd9, pc_mid: 6'd63, drop: 1'b0, exp: B9};

    // Reset with a request pending: nothing accepted, outputs cleared.
    reset = 1'b1; imem_read = 1'b1; imem_pc = 6'd5;
    imem_read1 = 1'b0; imem_pc1 = 6'd0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    cycle(); cycle();
    #1;
    chk("bw under reset", {127'b0, bw}, 128'd0);
    chk("rdata reset", rdata, 128'd0);
    chk("bw1 under reset", {127'b0, bw1}, 128'd0);
    chk("rdata1 reset", rdata1, 128'd0);
    reset = 1'b0; imem_read = 1'b0;
    #1;
    chk("no accept in reset", {127'b0, bw}, 128'd0);

    // Fill every block with a known pattern, then the specific images.
    for (int a = 0; a < 1024; a++) load_byte(10'(a), 8'(a * 37 + 11));
    for (int n = 0; n < 16; n++) load_byte(10'(10'h050 + n), 8'(n));
    for (int n = 0; n < 16; n++) load_byte(10'(10'h090 + n), 8'(8'h10 + n));

    // Table: address change and read drop mid-transfer are both ignored.
    for (int v = 0; v < 4; v++) begin
      req(vecs[v].pc, vecs[v].pc_mid, vecs[v].drop, 1'b0, 1'b0, '0, '0, 1'b1, vecs[v].exp);
      imem_read = 1'b0;
      cycle();
    end

    // Back-to-back: read held through DONE is not accepted there.
    req(6'd5, 6'd5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, B5);
    imem_pc = 6'd9;
    #1;
    chk("done holds off b2b", {127'b0, bw}, 128'd0);
    cycle();
    req(6'd9, 6'd9, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, B9);
    imem_read = 1'b0;
    cycle();

    // Reset in the third busywait cycle abandons the transfer; memory survives.
    imem_read = 1'b1; imem_pc = 6'd5;
    #1; chk("rst seq busy0", {127'b0, bw}, 128'd1);
    cycle();
    #1; chk("rst seq busy1", {127'b0, bw}, 128'd1);
    cycle();
    #1; chk("rst seq busy2", {127'b0, bw}, 128'd1);
    reset = 1'b1;
    #1; chk("rst seq bw forced low", {127'b0, bw}, 128'd0);
    cycle();
    reset = 1'b0; imem_read = 1'b0;
    #1;
    chk("rst seq bw after", {127'b0, bw}, 128'd0);
    chk("rst seq rdata cleared", rdata, 128'd0);
    cycle();
    req(6'd5, 6'd5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, B5);
    imem_read = 1'b0;
    cycle();

    // Load on the capturing edge: capture shows the old byte, next read the new one.
    req(6'd5, 6'd5, 1'b0, 1'b0, 1'b1, 10'h050, 8'hAA, 1'b1, B5);
    chk("rbw low byte", {120'b0, rdata[7:0]}, 128'h00);
    imem_read = 1'b0;
    cycle();
    req(6'd5, 6'd5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, B5AA);
    imem_read = 1'b0;
    cycle();

    // LATENCY=1 build: one busy cycle, data the next cycle.
    imem_read1 = 1'b1; imem_pc1 = 6'd63;
    #1; chk("lat1 busy", {127'b0, bw1}, 128'd1);
    snap = model[63];
    cycle();
    imem_read1 = 1'b0;
    #1;
    chk("lat1 done low", {127'b0, bw1}, 128'd0);
    chk("lat1 data blk63", rdata1, snap);
    cycle();
    imem_read1 = 1'b1; imem_pc1 = 6'd5;
    #1; chk("lat1 busy blk5", {127'b0, bw1}, 128'd1);
    cycle();
    imem_read1 = 1'b0;
    #1; chk("lat1 data blk5", rdata1, B5AA);
    cycle();

    // Random requests with random loads in flight, against the reference memory.
    for (int r = 0; r < 40; r++) begin
      req(6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, '0, 1'b0, '0);
      imem_read = 1'b0;
      #1; chk("idle bw low", {127'b0, bw}, 128'd0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
